regfile_dump: RTL and testbench

- Debug/trace reader for the 32x32 register file.
- On a start pulse it walks a contiguous, wrap-around address range on one register-file read port.
- It captures each word and streams it out over a valid/ready channel tagged with its address.
- Sits between the register file's spare read port (Address/RegDataR) and the SoC debug/UART trace path.

---
 rtl/regfile_dump.sv | 131 +++++++++++++
 tb/tb_regfile_dump.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// Register-file dump engine: walks a wrap-around address range on a spare
// read port and streams each captured word out over a valid/ready channel.
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] stop_q, stop_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;

    logic              capture;
    logic [ADDR_W-1:0] cur_inc;

    // The output slot can take a new word when empty or being drained this cycle.
    assign capture = !out_valid_q || out_ready;
    assign cur_inc = (cur_q == ADDR_W'(NUM_REGS - 1)) ? '0 : cur_q + ADDR_W'(1);

    // Next-state, walk pointer and output register updates.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        stop_d      = stop_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_d   = first_addr;
                    stop_d  = last_addr;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end else if (capture) begin
                    // Register 0 is hardwired to zero regardless of the port data.
                    out_data_d  = (cur_q == '0) ? '0 : rf_data;
                    out_addr_d  = cur_q;
                    out_valid_d = 1'b1;
                    out_last_d  = (cur_q == stop_q);
                    if (cur_q == stop_q) begin
                        state_d = DRAIN;
                    end else begin
                        cur_d = cur_inc;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            stop_q      <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            stop_q      <= stop_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign rf_addr   = (state_q == RUN) ? cur_q : '0;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == FIN);

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump with a combinational register-file model.
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [4:0]  first_addr;
    logic [4:0]  last_addr;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] rf_mem [32];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic        l;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    assign rf_data = rf_mem[rf_addr];

    regfile_dump #(
        .NUM_REGS(32),
        .ADDR_W  (5),
        .DATA_W  (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .first_addr(first_addr),
        .last_addr (last_addr),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d, input logic l);
        exp_t e;
        e.a = a;
        e.d = d;
        e.l = l;
        exp_q.push_back(e);
    endtask

    // Reference range walk: length ((l-f) mod 32)+1, register 0 reads as zero.
    task automatic push_range(input int f, input int l);
        int len;
        int a;
        len = ((l - f + 32) % 32) + 1;
        for (int i = 0; i < len; i++) begin
            a = (f + i) % 32;
            push(5'(a), (a == 0) ? 32'h0 : rf_mem[a], (i == len - 1));
        end
    endtask

    // Accept words until the expected queue drains, then verify the done pulse.
    // mode 0: out_ready held 1; mode 1: out_ready toggles 1,0,1,0...
    task automatic consume(input int mode, input int budget, output int nticks);
        logic       finished;
        logic       stall;
        logic       hs;
        logic [4:0] prev_rf;
        exp_t       e;
        finished = 1'b0;
        nticks   = 0;
        while (!finished && nticks < budget) begin
            out_ready = (mode == 1) ? ((nticks % 2) == 0) : 1'b1;
            check("no_early_done", {63'b0, done}, 64'd0);
            stall   = out_valid && !out_ready;
            hs      = out_valid && out_ready;
            prev_rf = rf_addr;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    check("extra_word_valid", {63'b0, out_valid}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("word_addr", {59'b0, out_addr}, {59'b0, e.a});
                    check("word_data", {32'b0, out_data}, {32'b0, e.d});
                    check("word_last", {63'b0, out_last}, {63'b0, e.l});
                    if (exp_q.size() == 0) finished = 1'b1;
                end
            end
            tick();
            nticks++;
            if (stall) check("rf_addr_frozen", {59'b0, rf_addr}, {59'b0, prev_rf});
        end
        check("consume_completed", {63'b0, finished}, 64'd1);
        check("done_pulse", {63'b0, done}, 64'd1);
        check("busy_with_done", {63'b0, busy}, 64'd0);
        check("valid_after_last", {63'b0, out_valid}, 64'd0);
        check("last_after_last", {63'b0, out_last}, 64'd0);
        tick();
        check("done_one_cycle", {63'b0, done}, 64'd0);
        check("idle_busy", {63'b0, busy}, 64'd0);
    endtask

    initial begin
        int n;

        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h100 + 32'(i);
        rf_mem[0] = 32'hDEADBEEF;

        rst        = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        out_ready  = 1'b0;
        tick();
        tick();
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_valid", {63'b0, out_valid}, 64'd0);
        check("rst_last", {63'b0, out_last}, 64'd0);
        check("rst_addr", {59'b0, out_addr}, 64'd0);
        check("rst_data", {32'b0, out_data}, 64'd0);
        check("rst_rf_addr", {59'b0, rf_addr}, 64'd0);
        rst = 1'b1;
        tick();

        // Basic range 1..4 at full rate.
        out_ready = 1'b1;
        start_dump(5'd1, 5'd4);
        check("t1_busy", {63'b0, busy}, 64'd1);
        check("t1_rf_addr_first", {59'b0, rf_addr}, 64'd1);
        check("t1_valid_latency", {63'b0, out_valid}, 64'd0);
        push(5'd1, 32'h101, 1'b0);
        push(5'd2, 32'h102, 1'b0);
        push(5'd3, 32'h103, 1'b0);
        push(5'd4, 32'h104, 1'b1);
        consume(0, 50, n);
        check("t1_cycles", 64'(n), 64'd5);

        // Wrap-around 30..1; register 0 reads zero despite the port data.
        start_dump(5'd30, 5'd1);
        push(5'd30, 32'h11E, 1'b0);
        push(5'd31, 32'h11F, 1'b0);
        push(5'd0, 32'h0, 1'b0);
        push(5'd1, 32'h101, 1'b1);
        consume(0, 50, n);
        check("t2_cycles", 64'(n), 64'd5);

        // Single word under six cycles of backpressure.
        out_ready = 1'b0;
        start_dump(5'd5, 5'd5);
        check("t3_valid_latency", {63'b0, out_valid}, 64'd0);
        tick();
        for (int i = 0; i < 6; i++) begin
            check("t3_hold_valid", {63'b0, out_valid}, 64'd1);
            check("t3_hold_addr", {59'b0, out_addr}, 64'd5);
            check("t3_hold_data", {32'b0, out_data}, 64'h105);
            check("t3_hold_last", {63'b0, out_last}, 64'd1);
            check("t3_hold_done", {63'b0, done}, 64'd0);
            tick();
        end
        push(5'd5, 32'h105, 1'b1);
        consume(0, 10, n);
        check("t3_cycles", 64'(n), 64'd1);

        // Toggling ready over 0..7.
        out_ready = 1'b1;
        start_dump(5'd0, 5'd7);
        push_range(0, 7);
        consume(1, 100, n);
        check("t4_all_words", 64'(exp_q.size()), 64'd0);

        // Abort after the second handshake of 10..20.
        out_ready = 1'b1;
        start_dump(5'd10, 5'd20);
        check("t5_valid_latency", {63'b0, out_valid}, 64'd0);
        check("t5_rf_addr", {59'b0, rf_addr}, 64'd10);
        tick();
        check("t5_w0_addr", {59'b0, out_addr}, 64'd10);
        check("t5_w0_data", {32'b0, out_data}, 64'h10A);
        tick();
        check("t5_w1_addr", {59'b0, out_addr}, 64'd11);
        tick();
        check("t5_w2_addr", {59'b0, out_addr}, 64'd12);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_abort_busy", {63'b0, busy}, 64'd0);
        check("t5_abort_valid", {63'b0, out_valid}, 64'd0);
        check("t5_abort_last", {63'b0, out_last}, 64'd0);
        check("t5_abort_done", {63'b0, done}, 64'd0);
        check("t5_abort_rf_addr", {59'b0, rf_addr}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_no_done", {63'b0, done}, 64'd0);
            check("t5_stay_idle", {63'b0, busy}, 64'd0);
        end
        start_dump(5'd3, 5'd3);
        push(5'd3, 32'h103, 1'b1);
        consume(0, 10, n);
        check("t5_restart_cycles", 64'(n), 64'd2);

        // Start during busy is ignored; reset mid-dump clears everything.
        out_ready = 1'b1;
        start_dump(5'd8, 5'd15);
        tick();
        tick();
        first_addr = 5'd20;
        last_addr  = 5'd25;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        check("t6_ignore_addr", {59'b0, out_addr}, 64'd10);
        check("t6_ignore_data", {32'b0, out_data}, 64'h10A);
        check("t6_ignore_rf_addr", {59'b0, rf_addr}, 64'd11);
        check("t6_ignore_last", {63'b0, out_last}, 64'd0);
        tick();
        check("t6_continue_addr", {59'b0, out_addr}, 64'd11);
        check("t6_continue_busy", {63'b0, busy}, 64'd1);
        rst = 1'b0;
        tick();
        check("t6_rst_busy", {63'b0, busy}, 64'd0);
        check("t6_rst_valid", {63'b0, out_valid}, 64'd0);
        check("t6_rst_addr", {59'b0, out_addr}, 64'd0);
        check("t6_rst_data", {32'b0, out_data}, 64'd0);
        check("t6_rst_last", {63'b0, out_last}, 64'd0);
        check("t6_rst_rf_addr", {59'b0, rf_addr}, 64'd0);
        rst = 1'b1;
        tick();
        check("t6_post_done", {63'b0, done}, 64'd0);
        check("t6_post_busy", {63'b0, busy}, 64'd0);
        check("t6_post_valid", {63'b0, out_valid}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
